// File: rtl/req_resp_responder.sv
// Responder side of a req/resp handshake: each request is answered 1 or 2 cycles later, with its tag echoed.
// Define RESP_CHECK_EN to compile the embedded latency, occupancy and ordering assertions.
module req_resp_responder #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             slow,
  output logic             resp,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       pending,
  output logic [CNT_W-1:0] resp_cnt
);

  // s1 is due on the next edge, s2 on the one after.
  logic             r_s1_v;
  logic             r_s2_v;
  logic [TAG_W-1:0] r_s1_tag;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s1_v_n;
  logic             w_s2_v_n;
  logic [TAG_W-1:0] w_s1_tag_n;

  // A fast request that meets an occupied s2 is demoted into s2 while s2 advances into s1.
  // This keeps at most one response due per cycle.
  always_comb begin
    w_s1_v_n   = r_s2_v | (req & ~slow);
    w_s1_tag_n = r_s2_v ? r_s2_tag : req_tag;
    w_s2_v_n   = req & (slow | r_s2_v);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s2_tag <= '0;
      resp     <= 1'b0;
      resp_tag <= '0;
      resp_cnt <= '0;
    end else begin
      r_s1_v   <= w_s1_v_n;
      r_s1_tag <= w_s1_tag_n;
      r_s2_v   <= w_s2_v_n;
      r_s2_tag <= req_tag;
      resp     <= r_s1_v;
      resp_tag <= r_s1_v ? r_s1_tag : '0;
      if (resp && (resp_cnt != {CNT_W{1'b1}})) begin
        resp_cnt <= resp_cnt + CNT_W'(1);
      end
    end
  end

  assign pending = {1'b0, r_s1_v} + {1'b0, r_s2_v};

`ifdef RESP_CHECK_EN
  // Shadow FIFO of outstanding tags, used only to check response ordering.
  logic [TAG_W-1:0] r_chk_q [4];
  logic [2:0]       r_chk_cnt;
  logic [TAG_W-1:0] w_chk_q_n [4];
  logic [2:0]       w_chk_cnt_n;

  always_comb begin
    w_chk_q_n   = r_chk_q;
    w_chk_cnt_n = r_chk_cnt;
    if (resp && (w_chk_cnt_n != 3'd0)) begin
      for (int i = 0; i < 3; i++) begin
        w_chk_q_n[i] = w_chk_q_n[i+1];
      end
      w_chk_cnt_n = w_chk_cnt_n - 3'd1;
    end
    if (req && (w_chk_cnt_n < 3'd4)) begin
      w_chk_q_n[w_chk_cnt_n[1:0]] = req_tag;
      w_chk_cnt_n                 = w_chk_cnt_n + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        r_chk_q[i] <= '0;
      end
    end else begin
      r_chk_cnt <= w_chk_cnt_n;
      r_chk_q   <= w_chk_q_n;
    end
  end

  // resp is registered, so an assertion sees it one edge after the edge that raised it.
  a_latency: assert property (@(posedge clk) disable iff (rst) req |=> ##[1:2] resp)
    else $error("req not answered within 1..2 cycles at %0t", $time);

  a_pending: assert property (@(posedge clk) disable iff (rst) pending != 2'd3)
    else $error("pending reached 3 at %0t", $time);

  a_order: assert property (@(posedge clk) disable iff (rst)
      resp |-> (r_chk_cnt != 3'd0) && (resp_tag == r_chk_q[0]))
    else $error("resp_tag is not the oldest outstanding tag at %0t", $time);
`endif

endmodule

// File: tb/tb_req_resp_responder.sv
// Directed self-checking bench for req_resp_responder: reset, single fast/slow requests,
// back-to-back demotion, continuous streaming with counter saturation, and mid-flight reset.
module tb_req_resp_responder;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [TAG_W-1:0] req_tag;
  logic             slow;
  logic             resp;
  logic [TAG_W-1:0] resp_tag;
  logic [1:0]       pending;
  logic [CNT_W-1:0] resp_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  req_resp_responder #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_tag  (req_tag),
    .slow     (slow),
    .resp     (resp),
    .resp_tag (resp_tag),
    .pending  (pending),
    .resp_cnt (resp_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic [TAG_W-1:0] t, input logic s);
    req     = r;
    req_tag = t;
    slow    = s;
  endtask

  task automatic check_out(input string name, input logic e_resp, input logic [TAG_W-1:0] e_tag,
                           input logic [1:0] e_pend);
    check({name, "_resp"}, 32'(resp), 32'(e_resp));
    check({name, "_tag"}, 32'(resp_tag), 32'(e_tag));
    check({name, "_pending"}, 32'(pending), 32'(e_pend));
  endtask

  // Back-to-back vectors: tags 1..4, slow 1,0,0,1, then idle.
  logic             t4_slow [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic             t4_resp [7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [TAG_W-1:0] t4_tag  [7]  = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
  logic [1:0]       t4_pend [7]  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};

  int sb_tag [$];
  int sb_edge[$];

  task automatic sb_pop();
    int t;
    int e;
    if (resp) begin
      if (sb_tag.size() == 0) begin
        check("t5_extra_resp", 32'(resp), 32'd0);
      end else begin
        t = sb_tag.pop_front();
        e = sb_edge.pop_front();
        check("t5_tag_order", 32'(resp_tag), 32'(t));
        check("t5_latency_in_1_2", 32'((cyc - e) >= 1 && (cyc - e) <= 2), 32'd1);
      end
    end
  endtask

  initial begin
    // 1. Reset
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    #2;
    check_out("t1_in_reset", 1'b0, 4'h0, 2'd0);
    check("t1_cnt_in_reset", 32'(resp_cnt), 32'd0);
    #6;
    check_out("t1_in_reset_edge", 1'b0, 4'h0, 2'd0);
    #4;
    rst = 1'b0;
    tick();
    check_out("t1_after_reset", 1'b0, 4'h0, 2'd0);
    check("t1_cnt_after_reset", 32'(resp_cnt), 32'd0);

    // 2. Single fast request
    drive(1'b1, 4'h5, 1'b0);
    tick();
    check_out("t2_n", 1'b0, 4'h0, 2'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    check_out("t2_n1", 1'b1, 4'h5, 2'd0);
    tick();
    check_out("t2_n2", 1'b0, 4'h0, 2'd0);
    check("t2_cnt", 32'(resp_cnt), 32'd1);

    // 3. Single slow request
    drive(1'b1, 4'hA, 1'b1);
    tick();
    check_out("t3_n", 1'b0, 4'h0, 2'd1);
    drive(1'b0, '0, 1'b0);
    tick();
    check_out("t3_n1", 1'b0, 4'h0, 2'd1);
    tick();
    check_out("t3_n2", 1'b1, 4'hA, 2'd0);
    tick();
    check_out("t3_n3", 1'b0, 4'h0, 2'd0);
    check("t3_cnt", 32'(resp_cnt), 32'd2);

    // 4. Back-to-back with demotion
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 4'(i + 1), t4_slow[i]);
      else       drive(1'b0, '0, 1'b0);
      tick();
      check_out($sformatf("t4_e%0d", i), t4_resp[i], t4_tag[i], t4_pend[i]);
    end
    check("t4_cnt", 32'(resp_cnt), 32'd6);

    // 5. Continuous requests, counter saturation, ordering scoreboard
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'(i), (i % 3) == 0);
      sb_tag.push_back(i % 16);
      sb_edge.push_back(cyc + 1);
      tick();
      if (i >= 2) check("t5_resp_every_cycle", 32'(resp), 32'd1);
      sb_pop();
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sb_pop();
    end
    check("t5_all_answered", 32'(sb_tag.size()), 32'd0);
    check("t5_cnt_saturated", 32'(resp_cnt), 32'd255);
    check_out("t5_idle", 1'b0, 4'h0, 2'd0);

    // 6. Reset mid-flight with two requests pending and a response on the output
    drive(1'b1, 4'h7, 1'b1);
    tick();
    drive(1'b1, 4'h8, 1'b1);
    tick();
    check("t6_pending_pre", 32'(pending), 32'd2);
    drive(1'b1, 4'h9, 1'b1);
    tick();
    check_out("t6_pre_reset", 1'b1, 4'h7, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check_out("t6_async_reset", 1'b0, 4'h0, 2'd0);
    check("t6_cnt_reset", 32'(resp_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out("t6_req_in_reset", 1'b0, 4'h0, 2'd0);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t6_after_release", 1'b0, 4'h0, 2'd0);
      check("t6_cnt_after_release", 32'(resp_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
